// File: rtl/keyboard_ctrl.sv
// keyboard_ctrl: PS/2 set-2 scan-code decoder for two players.
//   Tom uses the extended arrow keys (E0 6B/74/75), Jerry uses A/D/W (1C/23/1D).
//   Tracks F0 (break) and E0 (extended) prefixes; an unfinished prefix is
//   abandoned after TIMEOUT_CYCLES quiet cycles. Bytes 00/FF release every key.
// Optional build macro: KBD_JUMP_PULSE_EN turns both jump outputs into
//   one-cycle pulses on the first make of a press (typematic repeats ignored).
module keyboard_ctrl #(
  parameter int TIMEOUT_CYCLES = 130_000,
  parameter int CNT_W          = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic       tom_left,
  output logic       tom_right,
  output logic       tom_jump,
  output logic       jerry_left,
  output logic       jerry_right,
  output logic       jerry_jump,
  output logic       key_event
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  // Key vector bit order: 0 tom_left, 1 tom_right, 2 tom_jump,
  //                       3 jerry_left, 4 jerry_right, 5 jerry_jump
  localparam logic [5:0] LEVEL_MASK = 6'b011011;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       held, held_nxt;
  logic [5:0]       keys, keys_nxt;
  logic             event_nxt;
  logic             expired;

  function automatic logic [5:0] base_map(input logic [7:0] c);
    case (c)
      8'h1C:   return 6'b001000;
      8'h23:   return 6'b010000;
      8'h1D:   return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] ext_map(input logic [7:0] c);
    case (c)
      8'h6B:   return 6'b000001;
      8'h74:   return 6'b000010;
      8'h75:   return 6'b000100;
      default: return 6'b000000;
    endcase
  endfunction

  assign expired = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next prefix state and next held-key set from the incoming byte or a timeout
  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    if (code_valid) begin
      if (code == 8'h00 || code == 8'hFF) begin
        held_nxt  = '0;
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (code == 8'hF0)      state_nxt = BRK;
            else if (code == 8'hE0) state_nxt = EXT;
            else                    held_nxt  = held | base_map(code);
          end
          EXT: begin
            if (code == 8'hF0) state_nxt = EXT_BRK;
            else begin
              held_nxt  = held | ext_map(code);
              state_nxt = IDLE;
            end
          end
          BRK: begin
            if (code == 8'hF0)      state_nxt = BRK;
            else if (code == 8'hE0) state_nxt = EXT;
            else begin
              held_nxt  = held & ~base_map(code);
              state_nxt = IDLE;
            end
          end
          EXT_BRK: begin
            if (code == 8'hF0)      state_nxt = EXT_BRK;
            else if (code == 8'hE0) state_nxt = EXT;
            else begin
              held_nxt  = held & ~ext_map(code);
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (expired) begin
      state_nxt = IDLE;
    end
  end

  // Output shaping: jumps are levels or first-make pulses depending on the build
  always_comb begin
`ifdef KBD_JUMP_PULSE_EN
    keys_nxt    = held_nxt & LEVEL_MASK;
    keys_nxt[2] = held_nxt[2] & ~held[2];
    keys_nxt[5] = held_nxt[5] & ~held[5];
    event_nxt   = (|((held_nxt ^ held) & LEVEL_MASK)) | keys_nxt[2] | keys_nxt[5];
`else
    keys_nxt    = held_nxt;
    event_nxt   = |(held_nxt ^ held);
`endif
  end

  // Registered FSM, watchdog counter, held flags and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      held      <= '0;
      keys      <= '0;
      key_event <= 1'b0;
    end else begin
      state     <= state_nxt;
      held      <= held_nxt;
      keys      <= keys_nxt;
      key_event <= event_nxt;
      if (code_valid || state == IDLE || expired) cnt <= '0;
      else                                        cnt <= cnt + 1'b1;
    end
  end

  assign tom_left    = keys[0];
  assign tom_right   = keys[1];
  assign tom_jump    = keys[2];
  assign jerry_left  = keys[3];
  assign jerry_right = keys[4];
  assign jerry_jump  = keys[5];

endmodule

// File: tb/tb_keyboard_ctrl.sv
// tb_keyboard_ctrl: directed scenarios plus random byte streams for keyboard_ctrl,
// checked every cycle against a prefix/held-key reference model.
module tb_keyboard_ctrl;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code = 8'h00;
  logic       code_valid = 1'b0;
  logic       tom_left, tom_right, tom_jump, jerry_left, jerry_right, jerry_jump, key_event;

  int n_checks = 0;
  int n_fail   = 0;

  keyboard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .code(code), .code_valid(code_valid),
    .tom_left(tom_left), .tom_right(tom_right), .tom_jump(tom_jump),
    .jerry_left(jerry_left), .jerry_right(jerry_right), .jerry_jump(jerry_jump),
    .key_event(key_event)
  );

  always #5 clk = ~clk;

  // Reference model: pending prefixes as flags, quiet-cycle count, held keys
  bit       m_ext, m_brk;
  int       m_quiet;
  bit [5:0] m_held, m_out;
  bit       m_evt;

  function automatic int key_index(bit ext, bit [7:0] c);
    if (ext) begin
      if (c == 8'h6B) return 0;
      if (c == 8'h74) return 1;
      if (c == 8'h75) return 2;
    end else begin
      if (c == 8'h1C) return 3;
      if (c == 8'h23) return 4;
      if (c == 8'h1D) return 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_quiet = 0; m_held = '0; m_out = '0; m_evt = 0;
  endtask

  task automatic model_step(bit v, bit [7:0] c);
    bit [5:0] old = m_held;
    int idx;
    if (v) begin
      m_quiet = 0;
      if (c == 8'h00 || c == 8'hFF) begin
        m_held = '0; m_ext = 0; m_brk = 0;
      end else if (c == 8'hF0) begin
        m_brk = 1;
      end else if (c == 8'hE0) begin
        if (m_ext && !m_brk) begin m_ext = 0; m_brk = 0; end
        else begin m_ext = 1; m_brk = 0; end
      end else begin
        idx = key_index(m_ext, c);
        if (idx >= 0) m_held[idx] = !m_brk;
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      if (m_quiet == T - 1) begin m_ext = 0; m_brk = 0; m_quiet = 0; end
      else m_quiet++;
    end
`ifdef KBD_JUMP_PULSE_EN
    m_out = m_held & 6'b011011;
    m_out[2] = m_held[2] && !old[2];
    m_out[5] = m_held[5] && !old[5];
    m_evt = (((m_held ^ old) & 6'b011011) != 0) || m_out[2] || m_out[5];
`else
    m_out = m_held;
    m_evt = (m_held != old);
`endif
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_vec();
    return {key_event, jerry_jump, jerry_right, jerry_left, tom_jump, tom_right, tom_left};
  endfunction

  // One clock cycle: drive at negedge, sample 1 time unit after posedge
  task automatic cycle(bit r, bit v, bit [7:0] c);
    @(negedge clk);
    rst = r; code_valid = v; code = v ? c : 8'($urandom);
    @(posedge clk);
    #1;
    if (r) model_reset(); else model_step(v, c);
    check("outputs", 32'(dut_vec()), 32'({m_evt, m_out}));
  endtask

  task automatic send(bit [7:0] c);
    cycle(0, 1, c);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00);
  endtask

  logic [7:0] tbl [12] = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h1D, 8'h6B,
                           8'h74, 8'h75, 8'h00, 8'hFF, 8'hAA, 8'hE1};

  initial begin
    int pulses;
    int r;
    model_reset();
    cycle(1, 0, 8'h00);
    cycle(1, 0, 8'h00);
    check("reset_state", 32'(dut_vec()), 32'h0);

`ifndef KBD_JUMP_PULSE_EN
    // Up arrow make, then extended break
    send(8'hE0); send(8'h75);
    check("t1_jump_set", 32'(tom_jump), 32'h1);
    check("t1_event", 32'(key_event), 32'h1);
    idle(1);
    check("t1_event_once", 32'(key_event), 32'h0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t1_jump_clr", 32'(tom_jump), 32'h0);
`endif

    // Typematic A, then break
    pulses = 0;
    send(8'h1C); pulses += key_event;
    send(8'h1C); pulses += key_event;
    send(8'h1C); pulses += key_event;
    check("t2_left_held", 32'(jerry_left), 32'h1);
    check("t2_one_event", 32'(pulses), 32'h1);
    send(8'hF0); send(8'h1C);
    check("t2_left_clr", 32'(jerry_left), 32'h0);
    check("t2_brk_event", 32'(key_event), 32'h1);

    // Prefix timeout, then keypad 6B maps to nothing
    send(8'hE0); idle(T); send(8'h6B);
    check("t3_all_zero", 32'(dut_vec()), 32'h0);

    // Two held keys cleared by an overrun byte
    send(8'hE0); send(8'h74); send(8'h23);
    check("t4_both_held", 32'({tom_right, jerry_right}), 32'h3);
    send(8'hFF);
    check("t4_both_clr", 32'({tom_right, jerry_right}), 32'h0);
    check("t4_event", 32'(key_event), 32'h1);
    idle(1);
    check("t4_event_once", 32'(key_event), 32'h0);

    // Reset discards a pending break
    send(8'hF0); cycle(1, 0, 8'h00); send(8'h23);
    check("t5_right_set", 32'(jerry_right), 32'h1);

    // Coincident byte at the expiry cycle is still processed as a break
    send(8'hF0); idle(T - 1); send(8'h23);
    check("expiry_byte_wins", 32'(jerry_right), 32'h0);

`ifdef KBD_JUMP_PULSE_EN
    pulses = 0;
    send(8'h1D); pulses += jerry_jump;
    send(8'h1D); pulses += jerry_jump;
    send(8'hF0); pulses += jerry_jump;
    send(8'h1D); pulses += jerry_jump;
    send(8'h1D); pulses += jerry_jump;
    idle(2);
    check("t6_two_pulses", 32'(pulses), 32'h2);
`endif

    // Random byte streams with gaps long enough to hit the watchdog
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       cycle(1, 0, 8'h00);
      else if (r < 30) idle(int'($urandom_range(1, 3)));
      else if (r < 34) idle(int'($urandom_range(T - 2, T + 1)));
      else if (r < 38) send(8'($urandom));
      else             send(tbl[$urandom_range(0, 11)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
